// File: rtl/imem_loader.sv
// imem_loader: boot-time writer for the instruction memory.
//
// The loader receives a little-endian byte stream over a valid/ready handshake.
// The stream starts with a 32-bit word count N. N program words follow it.
// Each word is assembled and written to the instruction-memory write port.
// The core is held in reset until all N words have been written.
//
// Ports:
//   clk_i       system clock; all state changes on the rising edge
//   rst_ni      asynchronous active-low reset
//   s_valid_i   stream byte available
//   s_data_i    stream byte
//   s_ready_o   loader accepts a byte (HDR/DATA only)
//   load_req_i  one-cycle reload request; only acted on in DONE
//   mem_we_o    instruction-memory write enable, one pulse per word
//   mem_addr_o  byte address of the word being written (registered)
//   mem_wd_o    word being written (registered)
//   core_rst_o  active-low core reset; 0 holds the core in reset
//   done_o      image fully written, core released
//   err_o       bad header (N==0 or N>DEPTH); sticky until rst_ni
module imem_loader #(
  parameter int unsigned DEPTH = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        s_valid_i,
  input  logic [7:0]  s_data_i,
  output logic        s_ready_o,
  input  logic        load_req_i,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  output logic        core_rst_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {HDR, DATA, WRITE, DONE, ERR} state_e;

  state_e        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [31:0]   n_q, n_d;
  logic [31:0]   word_q, word_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wd_q, wd_d;
  logic          accept;

  // The handshake and status outputs are decoded from the state.
  // This lets an asynchronous reset drop mem_we at once.
  assign s_ready_o  = (state_q == HDR) || (state_q == DATA);
  assign accept     = s_valid_i && s_ready_o;
  assign mem_we_o   = (state_q == WRITE);
  assign core_rst_o = (state_q == DONE);
  assign done_o     = (state_q == DONE);
  assign err_o      = (state_q == ERR);
  assign mem_addr_o = addr_q;
  assign mem_wd_o   = wd_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    n_d     = n_q;
    word_d  = word_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    case (state_q)
      HDR: begin
        if (accept) begin
          // Shift in from the top, so the first byte ends up in [7:0].
          n_d   = {s_data_i, n_q[31:8]};
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (n_d == 32'd0 || n_d > 32'(DEPTH)) begin
              state_d = ERR;
            end else begin
              state_d = DATA;
              idx_d   = '0;
            end
          end
        end
      end
      DATA: begin
        if (accept) begin
          word_d = {s_data_i, word_q[31:8]};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            // Load the write port on the same edge that enters WRITE.
            state_d = WRITE;
            wd_d    = word_d;
            addr_d  = 32'(idx_q) << 2;
          end
        end
      end
      WRITE: begin
        if (32'(idx_q) == n_q - 32'd1) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = DATA;
        end
      end
      DONE: begin
        if (load_req_i) begin
          state_d = HDR;
          cnt_d   = '0;
          idx_d   = '0;
          n_d     = '0;
        end
      end
      ERR:     state_d = ERR;
      default: state_d = HDR;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= HDR;
      cnt_q   <= '0;
      idx_q   <= '0;
      n_q     <= '0;
      word_q  <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
    end
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction-memory writer for the single-cycle RISC-V core. It receives a little-endian byte stream over a valid/ready handshake (word-count header followed by program words) and assembles 32-bit words. It writes each word into the instruction memory's write port and holds the core in reset until the whole image is written. It is the write side of the instruction memory, which the core otherwise only reads via PC.

## Interface
- DEPTH, 1024, instruction memory size in 32-bit words; the header word count must be 1..DEPTH.
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- s_valid  input  1  byte-stream source has a byte.
- s_data  input  8  stream byte.
- s_ready  output  1  loader can accept a byte.
- load_req  input  1  one-cycle request to reload; honoured only in DONE.
- mem_we  output  1  instruction-memory write enable, one-cycle pulse per word.
- mem_addr  output  32  byte address of the word being written (word index × 4).
- mem_wd  output  32  word being written.
- core_rst  output  1  active-low reset to the core; 0 = core held in reset.
- done  output  1  image fully written, core released.
- err  output  1  bad header detected; sticky until rst.

## Operation
- A byte transfer occurs on a rising edge with s_valid && s_ready. s_data is ignored otherwise.
- States:
  - HDR: collect 4 header bytes into N[31:0], little-endian.
  - DATA: collect 4 bytes per word, little-endian. The first byte is [7:0].
  - WRITE: one-cycle write of the assembled word.
  - DONE: image written, core released.
  - ERR: bad header, sticky.
- A 2-bit byte counter runs in HDR and DATA. It wraps 3→0 on the 4th byte.
- HDR, 4th byte accepted:
  - if N==0 or N>DEPTH → ERR;
  - else → DATA, word index cleared to 0.
- DATA, 4th byte accepted → WRITE.
- WRITE: mem_we=1, mem_addr=index<<2, mem_wd=assembled word.
  - If index==N-1 → DONE.
  - Otherwise index increments → DATA.
- DONE: core_rst=1 and done=1. load_req=1 → HDR with byte counter, index and N cleared.
- ERR: err=1, s_ready=0, core_rst=0. Exits only via rst.
- load_req is ignored in every state except DONE.
- The index is DEPTH-sized. N>DEPTH is rejected, so the index never wraps.
- mem_addr and mem_wd are registered and hold their last value outside WRITE. mem_we is 0 outside WRITE.

## Timing
- Reset values: state=HDR, s_ready=1, mem_we=0, mem_addr=0, mem_wd=0, core_rst=0, done=0, err=0. Byte counter, index and N are all 0.
- s_ready is decoded combinationally from state:
  - 1 in HDR and DATA;
  - 0 in WRITE, DONE and ERR.
- mem_we is asserted in the cycle after the edge that accepts the word's 4th byte, for exactly one cycle.
- Best-case throughput is 4 bytes per 5 cycles.
- done and core_rst rise in the cycle after the last WRITE cycle. Minimum load time is 4 + 5N cycles from the first header byte.
- Header gaps: s_valid low for any number of cycles stalls collection with no state change.
- DONE with load_req: core_rst falls and s_ready rises on the next cycle.
- rst asserted mid-load: all state returns to reset values immediately (asynchronous). A partial word is discarded and mem_we drops at once.
- A stream byte presented during WRITE is not accepted (s_ready=0). The source must hold it until s_ready returns.

## Test plan
- Header 02 00 00 00, then bytes 13 00 50 00 93 00 A0 00, s_valid held high → mem_we pulses at addr 0x0 wd 0x00500013 and addr 0x4 wd 0x00A00093. done=1 and core_rst=1 exactly one cycle after the second write. Total 14 cycles from the first byte.
- Same image with s_valid deasserted for 3 cycles between every byte → identical writes. No acceptance during gaps; mem_we never asserted twice per word.
- Header 00 00 00 00 → err=1 the cycle after the 4th byte, s_ready=0, core_rst=0, no mem_we. Further stream bytes are ignored.
- Header N=DEPTH+1 (0x401 with default DEPTH) → ERR as above. N=DEPTH=1024 is accepted, the last write is at addr 0xFFC, and then DONE.
- rst pulsed low after 2 data bytes of word 1 → outputs return to reset values at once. The reloaded image writes from addr 0 with no stale bytes.
- In DONE, pulse load_req, then send a 1-word image 6F 00 00 00 → core_rst=0 next cycle, one write at addr 0x0 wd 0x0000006F, then done=1 again.
